// File: rtl/spart_driver.sv
// spart_driver: stands in for the processor on the SPART I/O bus. It programs
// the baud divisor after reset or a br_cfg change, then echoes received bytes.
module spart_driver #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] echo_cnt
);

  typedef enum logic [2:0] {
    INIT_LO  = 3'd0,
    INIT_HI  = 3'd1,
    POLL_RX  = 3'd2,
    READ_RX  = 3'd3,
    POLL_TX  = 3'd4,
    WRITE_TX = 3'd5
  } state_t;

  state_t     state, next_state;
  logic [1:0] br_meta, br_sync;
  logic [1:0] cfg_lat, cfg_q;
  logic       pending;
  logic [7:0] rx_byte;
  logic [15:0] div_now, div_held;
  logic       drive_en;
  logic [7:0] dout;

  // Status is read over the bus; the rda/tbr pins are kept only so the port list matches.
  logic unused_pins;
  assign unused_pins = &{1'b0, rda, tbr};

  function automatic logic [15:0] div_for(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'(CLK_HZ / 4800);
      2'b01:   return 16'(CLK_HZ / 9600);
      2'b10:   return 16'(CLK_HZ / 19200);
      default: return 16'(CLK_HZ / 38400);
    endcase
  endfunction

  assign div_now  = div_for(br_sync);
  assign div_held = div_for(cfg_lat);

  // Two-flop synchroniser for the DIP switches; unreset so it tracks br_cfg through reset.
  always_ff @(posedge clk) begin
    br_meta <= br_cfg;
    br_sync <= br_meta;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT_LO;
    else     state <= next_state;
  end

  // Datapath: divisor latch, reprogram-pending flag, received byte, echo counter.
  // cfg_q takes the value latched at INIT_LO so it always names the divisor actually
  // written; a switch change during INIT_HI is then caught as a mismatch and reprogrammed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_lat  <= '0;
      cfg_q    <= '0;
      pending  <= 1'b0;
      rx_byte  <= '0;
      echo_cnt <= '0;
    end else begin
      if (state == INIT_LO) cfg_lat <= br_sync;
      if (state == INIT_HI) begin
        cfg_q   <= cfg_lat;
        pending <= 1'b0;
      end else if (br_sync != cfg_q) begin
        pending <= 1'b1;
      end
      if (state == READ_RX)  rx_byte  <= databus;
      if (state == WRITE_TX) echo_cnt <= echo_cnt + 8'd1;
    end
  end

  // Next-state logic; status bits are sampled from the bus at the end of the poll cycle.
  always_comb begin
    next_state = INIT_LO;
    case (state)
      INIT_LO:  next_state = INIT_HI;
      INIT_HI:  next_state = POLL_RX;
      POLL_RX:  if (pending)         next_state = INIT_LO;
                else if (databus[0]) next_state = READ_RX;
                else                 next_state = POLL_RX;
      READ_RX:  next_state = POLL_TX;
      POLL_TX:  next_state = databus[1] ? WRITE_TX : POLL_TX;
      WRITE_TX: next_state = POLL_RX;
      default:  next_state = INIT_LO;
    endcase
  end

  // Bus outputs; reset forces the bus idle and released without waiting for a clock.
  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = 2'b00;
    drive_en = 1'b0;
    dout     = '0;
    if (!rst) begin
      case (state)
        INIT_LO: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10; drive_en = 1'b1; dout = div_now[7:0];
        end
        INIT_HI: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; drive_en = 1'b1; dout = div_held[15:8];
        end
        POLL_RX: begin
          if (!pending) begin
            iocs = 1'b1; ioaddr = 2'b01;
          end
        end
        READ_RX: begin
          iocs = 1'b1; ioaddr = 2'b00;
        end
        POLL_TX: begin
          iocs = 1'b1; ioaddr = 2'b01;
        end
        WRITE_TX: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drive_en = 1'b1; dout = rx_byte;
        end
        default: ;
      endcase
    end
  end

  assign databus = drive_en ? dout : 8'bz;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver with a behavioural SPART on the shared bus.
module tb_spart_driver;
  localparam int unsigned CLK_HZ = 50_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       tbr_r = 1'b1;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic [7:0] echo_cnt;
  wire  [7:0] databus;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // SPART model: receive FIFO, status register, log of every write access.
  logic [7:0]  rx_mem [0:1023];
  int unsigned rx_wr = 0;
  int unsigned rx_rd = 0;
  logic        rda;
  logic [7:0]  rx_head, status;
  logic [9:0]  wr_log [$];
  logic [2:0]  prev_acc = 3'b000;

  assign rda     = (rx_wr != rx_rd);
  assign rx_head = rx_mem[rx_rd[9:0]];
  assign status  = {6'b0, tbr_r, rda};
  assign databus = (iocs && iorw) ? ((ioaddr == 2'b01) ? status : rx_head) : 8'bz;

  spart_driver #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr_r),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .echo_cnt(echo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  always @(posedge clk) begin
    if (!rst && iocs) begin
      if (!iorw) wr_log.push_back({ioaddr, databus});
      else if (ioaddr == 2'b00 && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
  end

  // Bus-protocol monitor: released bus when idle, no write without chip select,
  // no INIT register written on two consecutive cycles.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (iorw && !iocs && !(databus === 8'bz || databus === 8'h00)) begin
        errors++;
        $display("FAIL bus_idle_released: databus=%h required z", databus);
      end
      checks++;
      if (!iorw && !iocs) begin
        errors++;
        $display("FAIL write_without_cs: iocs=%b iorw=%b required iocs=1", iocs, iorw);
      end
      checks++;
      if (iocs && !iorw && ioaddr[1] && prev_acc == {1'b1, ioaddr}) begin
        errors++;
        $display("FAIL init_double_access: ioaddr=%b held for 2 cycles, required 1", ioaddr);
      end
      prev_acc <= (iocs && !iorw) ? {1'b1, ioaddr} : 3'b000;
    end else begin
      prev_acc <= 3'b000;
    end
  end

  function automatic logic [15:0] div_of(input logic [1:0] cfg);
    int unsigned baud;
    baud = 4800 << cfg;
    return 16'(CLK_HZ / baud);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wr[9:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic flush_model();
    wr_log.delete();
    rx_wr   = rx_rd;
    exp_cnt = 0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (wr_log.size() >= n);
  endtask

  task automatic wait_read(input int budget, output bit ok);
    int k = 0;
    while (rx_rd != rx_wr && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_rd == rx_wr);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [9:0]  e;
    d = div_of(2'b01);
    br_cfg = 2'b01;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (iocs !== 1'b0 || iorw !== 1'b1 || echo_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: iocs=%b iorw=%b echo_cnt=%h required 0 1 00", iocs, iorw, echo_cnt);
    end
    checks++;
    if (!(databus === 8'bz || databus === 8'h00)) begin
      errors++;
      $display("FAIL reset_databus: databus=%h required z", databus);
    end
    flush_model();
    rst = 1'b0;
    #1;
    checks++;
    if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b0, 2'b10, d[7:0]}) begin
      errors++;
      $display("FAIL init_lo: cs=%b rw=%b addr=%b data=%h required 1 0 10 %h", iocs, iorw, ioaddr, databus, d[7:0]);
    end
    @(negedge clk);
    checks++;
    if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b0, 2'b11, d[15:8]}) begin
      errors++;
      $display("FAIL init_hi: cs=%b rw=%b addr=%b data=%h required 1 0 11 %h", iocs, iorw, ioaddr, databus, d[15:8]);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({iocs, iorw, ioaddr} !== 4'b1101) begin
        errors++;
        $display("FAIL status_poll: cs=%b rw=%b addr=%b required 1 1 01", iocs, iorw, ioaddr);
      end
    end
    checks++;
    if (wr_log.size() != 2) begin
      errors++;
      $display("FAIL init_write_count: got %0d required 2", wr_log.size());
    end else begin
      e = wr_log.pop_front();
      checks++;
      if (e !== {2'b10, d[7:0]}) begin errors++; $display("FAIL init_log_lo: got %h required %h", e, {2'b10, d[7:0]}); end
      e = wr_log.pop_front();
      if (e !== {2'b11, d[15:8]}) begin errors++; $display("FAIL init_log_hi: got %h required %h", e, {2'b11, d[15:8]}); end
    end
  endtask

  task automatic test_echo_fixed();
    bit ok;
    logic [9:0] e;
    tbr_r = 1'b1;
    checks++;
    if (echo_cnt !== 8'h00) begin errors++; $display("FAIL echo_cnt_before: got %h required 00", echo_cnt); end
    push_byte(8'h41);
    wait_log(1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL echo_timeout: no write seen, required write of 41");
    end else begin
      e = wr_log.pop_front();
      exp_cnt++;
      @(negedge clk);
      if (e !== {2'b00, 8'h41}) begin errors++; $display("FAIL echo_41: got %h required 041", e); end
      checks++;
      if (echo_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL echo_cnt_one: got %h required %h", echo_cnt, 8'(exp_cnt)); end
    end
  endtask

  task automatic test_tbr_stall();
    bit ok;
    logic [9:0] e;
    tbr_r = 1'b0;
    push_byte(8'hC3);
    wait_read(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_read_timeout: byte not read, required read"); end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({iocs, iorw, ioaddr} !== 4'b1101) begin
        errors++;
        $display("FAIL stall_poll_tx: cs=%b rw=%b addr=%b required 1 1 01", iocs, iorw, ioaddr);
      end
    end
    checks++;
    if (wr_log.size() != 0) begin errors++; $display("FAIL stall_no_write: got %0d writes required 0", wr_log.size()); end
    tbr_r = 1'b1;
    wait_log(1, 20, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (wr_log.size() != 1) begin
      errors++;
      $display("FAIL stall_single_write: got %0d writes required 1", wr_log.size());
      wr_log.delete();
    end else begin
      e = wr_log.pop_front();
      exp_cnt++;
      checks++;
      if (e !== {2'b00, 8'hC3}) begin errors++; $display("FAIL stall_byte: got %h required 0c3", e); end
    end
    checks++;
    if (echo_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL stall_echo_cnt: got %h required %h", echo_cnt, 8'(exp_cnt)); end
  endtask

  task automatic test_reprogram();
    bit ok;
    logic [9:0]  e;
    logic [15:0] d;
    logic [9:0]  want [3];
    d = div_of(2'b11);
    want[0] = {2'b00, 8'h9A};
    want[1] = {2'b10, d[7:0]};
    want[2] = {2'b11, d[15:8]};
    tbr_r = 1'b0;
    push_byte(8'h9A);
    wait_read(20, ok);
    repeat (3) @(negedge clk);
    br_cfg = 2'b11;
    repeat (8) @(negedge clk);
    tbr_r = 1'b1;
    wait_log(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reprogram_timeout: got %0d writes required 3", wr_log.size());
      wr_log.delete();
    end else begin
      exp_cnt++;
      for (int i = 0; i < 3; i++) begin
        e = wr_log.pop_front();
        checks++;
        if (e !== want[i]) begin errors++; $display("FAIL reprogram_seq%0d: got %h required %h", i, e, want[i]); end
      end
    end
    checks++;
    if (echo_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL reprogram_echo_cnt: got %h required %h", echo_cnt, 8'(exp_cnt)); end
  endtask

  task automatic test_echo_random(input int n);
    bit ok;
    logic [7:0] b;
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      tbr_r = 1'($urandom);
      push_byte(b);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      tbr_r = 1'b1;
      wait_log(1, 40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_timeout: byte %0d not echoed", i);
      end else begin
        e = wr_log.pop_front();
        exp_cnt++;
        @(negedge clk);
        if (e !== {2'b00, b}) begin errors++; $display("FAIL random_byte%0d: got %h required %h", i, e, {2'b00, b}); end
        checks++;
        if (echo_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL random_cnt%0d: got %h required %h", i, echo_cnt, 8'(exp_cnt)); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] b;
    logic [9:0] e;
    tbr_r = 1'b1;
    while (exp_cnt < 256) begin
      b = 8'($urandom);
      push_byte(b);
      wait_log(1, 40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wrap_timeout: echo %0d missing", exp_cnt);
        break;
      end
      e = wr_log.pop_front();
      exp_cnt++;
      if (e !== {2'b00, b}) begin errors++; $display("FAIL wrap_byte: got %h required %h", e, {2'b00, b}); end
    end
    @(negedge clk);
    checks++;
    if (echo_cnt !== 8'h00 || exp_cnt != 256) begin
      errors++;
      $display("FAIL echo_cnt_wrap: got %h after %0d echoes required 00 after 256", echo_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int k;
    logic [15:0] d;
    logic [9:0]  e;
    tbr_r = 1'b0;
    push_byte(8'h7E);
    wait_read(20, ok);
    tbr_r = 1'b1;
    k = 0;
    while (!(iocs && !iorw && ioaddr == 2'b00) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(iocs && !iorw && ioaddr == 2'b00)) begin
      errors++;
      $display("FAIL midwrite_timeout: WRITE_TX not reached");
    end
    br_cfg = 2'b10;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (iocs !== 1'b0 || iorw !== 1'b1 || echo_cnt !== 8'h00) begin
      errors++;
      $display("FAIL midwrite_abort: iocs=%b iorw=%b echo_cnt=%h required 0 1 00", iocs, iorw, echo_cnt);
    end
    checks++;
    if (!(databus === 8'bz || databus === 8'h00)) begin
      errors++;
      $display("FAIL midwrite_release: databus=%h required z", databus);
    end
    repeat (4) @(negedge clk);
    flush_model();
    d = div_of(2'b10);
    rst = 1'b0;
    wait_log(2, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reinit_timeout: got %0d writes required 2", wr_log.size());
    end else begin
      e = wr_log.pop_front();
      if (e !== {2'b10, d[7:0]}) begin errors++; $display("FAIL reinit_lo: got %h required %h", e, {2'b10, d[7:0]}); end
      e = wr_log.pop_front();
      checks++;
      if (e !== {2'b11, d[15:8]}) begin errors++; $display("FAIL reinit_hi: got %h required %h", e, {2'b11, d[15:8]}); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rx_mem[i] = 8'h00;
    test_reset();
    test_echo_fixed();
    test_tbr_stall();
    test_reprogram();
    test_echo_random(20);
    test_wrap();
    test_reset_mid_write();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
